// File: rtl/ntt_rns_sequencer.sv
// ntt_rns_sequencer: job-level controller that runs one NTT core over a batch
// of RNS residues. Jobs enter through a small descriptor FIFO. Each residue
// takes its modulus from a runtime-writable table and goes through
// host load -> core start -> core run -> host unload.
//
// Handshakes: load_req and unload_req stay high until the matching ack is
// sampled high on a rising edge. An ack that is present in the same cycle the
// req first rises is accepted. Each req drops in the cycle after its ack.
// core_start is a single-cycle pulse. core_done is honoured only in RUN.
// job_valid/job_ready follow normal valid/ready rules: a push happens on any
// edge where both are high.
module ntt_rns_sequencer #(
  parameter int WIDTH      = 32,
  parameter int MOD_IDX_W  = 6,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tbl_we,
  input  logic [MOD_IDX_W-1:0] tbl_addr,
  input  logic [WIDTH-1:0]     tbl_wdata,
  input  logic                 job_valid,
  output logic                 job_ready,
  input  logic [MOD_IDX_W-1:0] job_base,
  input  logic [MOD_IDX_W:0]   job_count,
  input  logic                 job_inverse,
  output logic                 load_req,
  input  logic                 load_ack,
  output logic                 core_start,
  output logic [WIDTH-1:0]     core_modulus,
  output logic                 core_inverse,
  input  logic                 core_done,
  output logic                 unload_req,
  input  logic                 unload_ack,
  output logic [MOD_IDX_W-1:0] residue_idx,
  output logic                 job_done,
  output logic                 busy,
  output logic                 err,
  output logic [2:0]           dbg_state
);

  localparam int NUM_MODULI = 2**MOD_IDX_W;
  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0]     FULL_LEVEL = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [MOD_IDX_W:0] K_ONE      = (MOD_IDX_W+1)'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_POP, S_FETCH, S_LOAD, S_START, S_RUN, S_UNLOAD
  } state_t;

  state_t r_state, w_next;

  logic [WIDTH-1:0]     r_table [NUM_MODULI];
  logic [WIDTH-1:0]     r_rdata;
  logic [MOD_IDX_W-1:0] r_fifo_base [FIFO_DEPTH];
  logic [MOD_IDX_W:0]   r_fifo_cnt  [FIFO_DEPTH];
  logic                 r_fifo_inv  [FIFO_DEPTH];
  logic [PTR_W-1:0]     r_wr_ptr, r_rd_ptr;
  logic [PTR_W:0]       r_level;
  logic [MOD_IDX_W:0]   r_cnt, r_k;
  logic                 r_inv;
  logic [MOD_IDX_W-1:0] r_idx;
  logic [WIDTH-1:0]     r_core_mod;
  logic                 r_core_inv;
  logic                 r_err;

  logic w_push, w_pop, w_advance, w_last, w_zero_mod;

  assign job_ready    = (r_level != FULL_LEVEL);
  assign w_push       = job_valid && job_ready;
  assign w_zero_mod   = (r_rdata == '0);
  assign w_last       = ((r_k + K_ONE) == r_cnt);
  assign busy         = (r_state != S_IDLE) || (r_level != '0);
  assign err          = r_err;
  assign residue_idx  = r_idx;
  assign core_modulus = r_core_mod;
  assign core_inverse = r_core_inv;
  assign dbg_state    = r_state;

  // Modulus table RAM plus its registered read port. The read happens in
  // FETCH, so a write to the same index in that cycle yields the old value.
  always_ff @(posedge clk) begin
    if (tbl_we) r_table[tbl_addr] <= tbl_wdata;
    if (r_state == S_FETCH) r_rdata <= r_table[r_idx];
  end

  // Descriptor FIFO storage. The level and pointers are reset elsewhere.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_base[r_wr_ptr] <= job_base;
      r_fifo_cnt[r_wr_ptr]  <= job_count;
      r_fifo_inv[r_wr_ptr]  <= job_inverse;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next state and handshake outputs. Skipping a zero-modulus residue and
  // completing an unload share the same advance path.
  always_comb begin
    w_next     = r_state;
    load_req   = 1'b0;
    core_start = 1'b0;
    unload_req = 1'b0;
    job_done   = 1'b0;
    w_pop      = 1'b0;
    w_advance  = 1'b0;
    case (r_state)
      S_IDLE:  if (r_level != '0) w_next = S_POP;
      S_POP: begin
        w_pop = 1'b1;
        if (r_fifo_cnt[r_rd_ptr] == '0) begin
          job_done = 1'b1;
          w_next   = S_IDLE;
        end else begin
          w_next = S_FETCH;
        end
      end
      S_FETCH: w_next = S_LOAD;
      S_LOAD: begin
        if (w_zero_mod) begin
          w_advance = 1'b1;
        end else begin
          load_req = 1'b1;
          if (load_ack) w_next = S_START;
        end
      end
      S_START: begin
        core_start = 1'b1;
        w_next     = S_RUN;
      end
      S_RUN:   if (core_done) w_next = S_UNLOAD;
      S_UNLOAD: begin
        unload_req = 1'b1;
        if (unload_ack) w_advance = 1'b1;
      end
      default: w_next = S_IDLE;
    endcase
    if (w_advance) begin
      if (w_last) begin
        job_done = 1'b1;
        w_next   = S_IDLE;
      end else begin
        w_next = S_FETCH;
      end
    end
  end

  // FIFO bookkeeping, per-job context, per-residue core settings, sticky error.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_cnt      <= '0;
      r_k        <= '0;
      r_inv      <= 1'b0;
      r_idx      <= '0;
      r_core_mod <= '0;
      r_core_inv <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_push && !w_pop)      r_level <= r_level + (PTR_W+1)'(1);
      else if (!w_push && w_pop) r_level <= r_level - (PTR_W+1)'(1);

      if (r_state == S_POP) begin
        r_cnt <= r_fifo_cnt[r_rd_ptr];
        r_inv <= r_fifo_inv[r_rd_ptr];
        r_idx <= r_fifo_base[r_rd_ptr];
        r_k   <= '0;
      end

      // Core settings settle during LOAD and stay frozen until the next LOAD.
      if (r_state == S_LOAD) begin
        if (w_zero_mod) begin
          r_err <= 1'b1;
        end else begin
          r_core_mod <= r_rdata;
          r_core_inv <= r_inv;
        end
      end

      // Table indices wrap naturally at the table depth.
      if (w_advance) begin
        r_k   <= r_k + K_ONE;
        r_idx <= r_idx + MOD_IDX_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ntt_rns_sequencer.sv
// Directed bench for ntt_rns_sequencer. A host/core responder acks each req
// after two extra cycles. The monitor compares each core_start against a queue
// of expected {inverse, index, modulus} entries.
module tb_ntt_rns_sequencer;
  localparam int WIDTH      = 32;
  localparam int MOD_IDX_W  = 6;
  localparam int FIFO_DEPTH = 4;
  localparam int EW         = 1 + MOD_IDX_W + WIDTH;

  // clock / reset and DUT signals
  logic                 clk = 1'b0;
  logic                 reset;
  logic                 tbl_we;
  logic [MOD_IDX_W-1:0] tbl_addr;
  logic [WIDTH-1:0]     tbl_wdata;
  logic                 job_valid, job_ready;
  logic [MOD_IDX_W-1:0] job_base;
  logic [MOD_IDX_W:0]   job_count;
  logic                 job_inverse;
  logic                 load_req, load_ack, core_start, core_inverse, core_done;
  logic [WIDTH-1:0]     core_modulus;
  logic                 unload_req, unload_ack, job_done, busy, err;
  logic [MOD_IDX_W-1:0] residue_idx;
  logic [2:0]           dbg_state;

  always #5 clk = ~clk;

  ntt_rns_sequencer #(.WIDTH(WIDTH), .MOD_IDX_W(MOD_IDX_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .reset(reset),
    .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_wdata(tbl_wdata),
    .job_valid(job_valid), .job_ready(job_ready), .job_base(job_base),
    .job_count(job_count), .job_inverse(job_inverse),
    .load_req(load_req), .load_ack(load_ack),
    .core_start(core_start), .core_modulus(core_modulus), .core_inverse(core_inverse),
    .core_done(core_done), .unload_req(unload_req), .unload_ack(unload_ack),
    .residue_idx(residue_idx), .job_done(job_done), .busy(busy), .err(err),
    .dbg_state(dbg_state)
  );

  // scoreboard
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] cur_exp = '0;
  int n_vec = 0, n_err = 0;
  int n_start = 0, n_load = 0, n_unload = 0, n_done = 0;
  int run_len = 3;
  bit hold_core = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, expv);
    end
  endtask

  task automatic expect_res(input logic [MOD_IDX_W-1:0] idx, input logic [WIDTH-1:0] m,
                            input logic inv);
    exp_q.push_back({inv, idx, m});
  endtask

  // host and core responder: ack after the req has been seen for two cycles
  initial begin : responder
    int ld_wait, ul_wait, run_cnt;
    ld_wait = 0; ul_wait = 0; run_cnt = 0;
    load_ack = 1'b0; unload_ack = 1'b0; core_done = 1'b0;
    forever begin
      @(negedge clk);
      load_ack = 1'b0; unload_ack = 1'b0; core_done = 1'b0;
      if (load_req) begin
        if (ld_wait == 2) begin load_ack = 1'b1; ld_wait = 0; end
        else ld_wait++;
      end else ld_wait = 0;
      if (unload_req) begin
        if (ul_wait == 2) begin unload_ack = 1'b1; ul_wait = 0; end
        else ul_wait++;
      end else ul_wait = 0;
      if (core_start) run_cnt = run_len;
      else if (!hold_core && run_cnt != 0) begin
        run_cnt--;
        if (run_cnt == 0) core_done = 1'b1;
      end
    end
  end

  // monitor: samples after the responder has driven its inputs for the cycle
  initial begin : monitor
    logic prev_start, prev_load, prev_unload;
    prev_start = 1'b0; prev_load = 1'b0; prev_unload = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (reset) begin
        prev_start = 1'b0; prev_load = 1'b0; prev_unload = 1'b0;
      end else begin
        if (core_start) begin
          n_start++;
          check("start_one_cycle", prev_start, 1'b0);
          if (exp_q.size() == 0) check("unexpected_start", core_start, 1'b0);
          else begin
            cur_exp = exp_q.pop_front();
            check("start_idx", residue_idx, cur_exp[WIDTH+MOD_IDX_W-1:WIDTH]);
            check("start_mod", core_modulus, cur_exp[WIDTH-1:0]);
            check("start_inv", core_inverse, cur_exp[EW-1]);
          end
        end
        if (unload_req && !prev_unload) begin
          n_unload++;
          check("unload_mod", core_modulus, cur_exp[WIDTH-1:0]);
          check("unload_inv", core_inverse, cur_exp[EW-1]);
        end
        if (load_req && !prev_load) n_load++;
        if (job_done) n_done++;
        prev_start = core_start; prev_load = load_req; prev_unload = unload_req;
      end
    end
  end

  // driver tasks (called at a falling edge)
  task automatic tbl_write(input logic [MOD_IDX_W-1:0] a, input logic [WIDTH-1:0] d);
    tbl_we = 1'b1; tbl_addr = a; tbl_wdata = d;
    @(negedge clk);
    tbl_we = 1'b0;
  endtask

  task automatic push_job(input logic [MOD_IDX_W-1:0] b, input logic [MOD_IDX_W:0] c,
                          input logic inv, output logic acc);
    job_valid = 1'b1; job_base = b; job_count = c; job_inverse = inv;
    acc = job_ready;
    @(negedge clk);
    job_valid = 1'b0;
  endtask

  task automatic wait_jobs(input int target, input int budget);
    int c = 0;
    while (n_done < target && c < budget) begin
      @(negedge clk); #3; c++;
    end
    check("jobs_done", n_done, target);
  endtask

  task automatic wait_starts(input int target, input int budget);
    int c = 0;
    while (n_start < target && c < budget) begin
      @(negedge clk); #3; c++;
    end
    check("starts_seen", n_start, target);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic acc;
    logic acc5 [5];
    int b_done, b_start, b_load;
    reset = 1'b1; tbl_we = 1'b0; tbl_addr = '0; tbl_wdata = '0;
    job_valid = 1'b0; job_base = '0; job_count = '0; job_inverse = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_job_ready", job_ready, 1'b1);
    check("rst_load_req", load_req, 1'b0);
    check("rst_core_start", core_start, 1'b0);
    check("rst_unload_req", unload_req, 1'b0);
    check("rst_job_done", job_done, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_core_modulus", core_modulus, 0);
    check("rst_residue_idx", residue_idx, 0);

    // two-residue forward job, with pop-to-load and ack-to-start latency
    tbl_write(3, 32'd4244570881);
    tbl_write(4, 32'd335539201);
    expect_res(3, 32'd4244570881, 1'b0);
    expect_res(4, 32'd335539201, 1'b0);
    b_done = n_done; b_load = n_load; b_start = n_start;
    push_job(3, 2, 1'b0, acc);
    check("t1_accept", acc, 1'b1);
    check("t1_busy", busy, 1'b1);
    @(negedge clk);
    check("t1_pop_no_load", load_req, 1'b0);
    @(negedge clk);
    check("t1_fetch_idx", residue_idx, 3);
    check("t1_fetch_no_load", load_req, 1'b0);
    @(negedge clk);
    check("t1_load_req", load_req, 1'b1);
    repeat (3) @(negedge clk);
    check("t1_core_start", core_start, 1'b1);
    check("t1_load_dropped", load_req, 1'b0);
    check("t1_core_modulus", core_modulus, 32'd4244570881);
    wait_jobs(b_done + 1, 200);
    repeat (5) @(negedge clk);
    check("t1_single_done", n_done, b_done + 1);
    check("t1_loads", n_load, b_load + 2);
    check("t1_starts", n_start, b_start + 2);
    check("t1_busy_end", busy, 1'b0);

    // FIFO fill while the core is stalled in RUN
    for (int i = 9; i <= 14; i++) tbl_write(MOD_IDX_W'(i), WIDTH'(1000 + i));
    hold_core = 1'b1;
    b_done = n_done; b_start = n_start;
    expect_res(9, 32'd1009, 1'b0);
    push_job(9, 1, 1'b0, acc);
    wait_starts(b_start + 1, 50);
    @(negedge clk);
    for (int i = 0; i < 5; i++) push_job(MOD_IDX_W'(10 + i), 1, 1'b0, acc5[i]);
    for (int i = 0; i < 5; i++) check($sformatf("t2_accept_%0d", i), acc5[i], (i < 4) ? 1'b1 : 1'b0);
    check("t2_full_ready", job_ready, 1'b0);
    for (int i = 10; i <= 13; i++) expect_res(MOD_IDX_W'(i), WIDTH'(1000 + i), 1'b0);
    hold_core = 1'b0;
    wait_jobs(b_done + 5, 600);
    check("t2_queue_drained", exp_q.size(), 0);
    check("t2_ready_back", job_ready, 1'b1);

    // index wrap 62, 63, 0
    tbl_write(62, 32'd7681);
    tbl_write(63, 32'd12289);
    tbl_write(0, 32'd40961);
    expect_res(62, 32'd7681, 1'b0);
    expect_res(63, 32'd12289, 1'b0);
    expect_res(0, 32'd40961, 1'b0);
    b_done = n_done;
    push_job(62, 3, 1'b0, acc);
    wait_jobs(b_done + 1, 300);
    check("t3_queue_drained", exp_q.size(), 0);

    // zero modulus skipped, err sticky
    tbl_write(6, 32'd65537);
    tbl_write(7, 32'd0);
    tbl_write(8, 32'd786433);
    expect_res(6, 32'd65537, 1'b0);
    expect_res(8, 32'd786433, 1'b0);
    b_done = n_done; b_load = n_load;
    push_job(6, 3, 1'b0, acc);
    wait_jobs(b_done + 1, 300);
    repeat (5) @(negedge clk);
    check("t4_single_done", n_done, b_done + 1);
    check("t4_loads", n_load, b_load + 2);
    check("t4_err", err, 1'b1);
    check("t4_queue_drained", exp_q.size(), 0);

    // empty job: job_done two cycles after the push cycle, no core activity
    @(negedge clk);
    b_start = n_start; b_done = n_done;
    push_job(20, 0, 1'b0, acc);
    check("t5_idle_no_done", job_done, 1'b0);
    @(negedge clk);
    check("t5_done_pulse", job_done, 1'b1);
    @(negedge clk);
    check("t5_done_low", job_done, 1'b0);
    check("t5_not_busy", busy, 1'b0);
    repeat (3) @(negedge clk);
    check("t5_no_start", n_start, b_start);
    check("t5_err_sticky", err, 1'b1);

    // table write during FETCH returns old value; inverse job
    tbl_write(5, 32'd101);
    expect_res(5, 32'd101, 1'b1);
    b_done = n_done;
    push_job(5, 1, 1'b1, acc);
    @(negedge clk);
    @(negedge clk);
    check("t6_fetch_idx", residue_idx, 5);
    tbl_write(5, 32'd202);
    wait_jobs(b_done + 1, 200);
    @(negedge clk);
    expect_res(5, 32'd202, 1'b0);
    push_job(5, 1, 1'b0, acc);
    wait_jobs(b_done + 2, 200);
    check("t6_queue_drained", exp_q.size(), 0);

    // reset during RUN aborts the job and discards queued ones
    hold_core = 1'b1;
    expect_res(3, 32'd4244570881, 1'b0);
    b_start = n_start;
    push_job(3, 1, 1'b0, acc);
    push_job(4, 1, 1'b0, acc);
    push_job(4, 1, 1'b0, acc);
    wait_starts(b_start + 1, 50);
    repeat (2) @(negedge clk);
    check("t7_in_run_busy", busy, 1'b1);
    exp_q.delete();
    b_start = n_start; b_done = n_done;
    reset = 1'b1;
    @(negedge clk);
    check("t7_load_req", load_req, 1'b0);
    check("t7_core_start", core_start, 1'b0);
    check("t7_unload_req", unload_req, 1'b0);
    check("t7_job_done", job_done, 1'b0);
    check("t7_job_ready", job_ready, 1'b1);
    check("t7_busy", busy, 1'b0);
    check("t7_err", err, 1'b0);
    check("t7_core_modulus", core_modulus, 0);
    reset = 1'b0;
    hold_core = 1'b0;
    repeat (30) @(negedge clk);
    check("t7_no_new_start", n_start, b_start);
    check("t7_no_done", n_done, b_done);
    check("t7_idle", busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
